// File: rtl/bpu_update_scheduler_pkg.sv
// Shared frontend definitions for the BPU update scheduler: FSM states,
// the default starvation limit and the branch-update payload layout.
package bpu_update_scheduler_pkg;

    typedef enum logic [1:0] {
        UPD_IDLE  = 2'd0,
        UPD_SHARE = 2'd1,
        UPD_FORCE = 2'd2
    } upd_state_e;

    localparam int unsigned STARVE_LIMIT_DEF = 8;

    typedef struct packed {
        logic [38:0] target;
        logic [18:0] tag;
        logic [2:0]  br_type;
        logic        taken;
        logic [1:0]  ctr;
    } BranchUpdateInfo;

    localparam int unsigned UPD_W_DEF = $bits(BranchUpdateInfo);

endpackage

// File: rtl/bpu_update_scheduler_upd_fifo.sv
// Update queue storage: circular buffer with registered occupancy count.
module upd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 din_i,
    output logic [W-1:0]                 dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/bpu_update_scheduler.sv
// Arbitrates the single-ported BPU array between prediction reads and queued
// training updates; reads win until the head starves or the queue fills.
module bpu_update_scheduler
    import bpu_update_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned IDX_W        = 9,
    parameter int unsigned UPD_W        = UPD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [UPD_W-1:0] upd_data,
    input  logic             pred_req,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_grant,
    output logic             pred_stall,
    input  logic             squash,
    output logic             arr_ren,
    output logic [IDX_W-1:0] arr_ridx,
    output logic             arr_wen,
    output logic [IDX_W-1:0] arr_widx,
    output logic [UPD_W-1:0] arr_wdata,
    output logic             q_empty
);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT+1);
    localparam int unsigned ENT_W = IDX_W + UPD_W;

    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_cnt, cnt_d;
    logic [ENT_W-1:0] fifo_head;
    logic             enq, wen;

    upd_state_e       state_q, state_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q;

    function automatic logic [STV_W-1:0] starve_sat_inc(input logic [STV_W-1:0] v);
        return (v == STV_W'(STARVE_LIMIT)) ? v : v + 1'b1;
    endfunction

    upd_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (enq),
        .pop_i   (wen),
        .din_i   ({upd_idx, upd_data}),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign upd_ready = !fifo_full;
    assign enq       = upd_valid && upd_ready;

    // Write-slot decision; the reset cycle never writes so a flushed queue
    // cannot leak its head into the array.
    always_comb begin
        wen = 1'b0;
        unique case (state_q)
            UPD_IDLE:  wen = 1'b0;
            UPD_SHARE: wen = !pred_req || squash;
            UPD_FORCE: wen = 1'b1;
            default:   wen = 1'b0;
        endcase
        wen = wen && !fifo_empty && !rst;
    end

    always_comb begin
        cnt_d    = fifo_cnt + CNT_W'(enq) - CNT_W'(wen);
        starve_d = '0;
        if (state_q == UPD_SHARE && !wen) begin
            starve_d = starve_sat_inc(starve_q);
        end

        state_d = state_q;
        unique case (state_q)
            UPD_IDLE: begin
                if (enq) state_d = UPD_SHARE;
            end
            UPD_SHARE: begin
                if (cnt_d == '0)
                    state_d = UPD_IDLE;
                else if (starve_d == STV_W'(STARVE_LIMIT) || cnt_d == CNT_W'(DEPTH))
                    state_d = UPD_FORCE;
            end
            UPD_FORCE: begin
                if (cnt_d == '0)
                    state_d = UPD_IDLE;
                else if (cnt_d <= CNT_W'(DEPTH / 2))
                    state_d = UPD_SHARE;
            end
            default: state_d = UPD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= UPD_IDLE;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            stall_q  <= (state_d == UPD_FORCE);
        end
    end

    assign arr_wen    = wen;
    assign {arr_widx, arr_wdata} = fifo_head;
    assign arr_ren    = pred_req && !wen && !squash;
    assign pred_grant = arr_ren;
    assign arr_ridx   = pred_idx;
    assign pred_stall = stall_q;
    assign q_empty    = fifo_empty;

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Scoreboard bench for bpu_update_scheduler: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_bpu_update_scheduler;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;
    localparam int IDX_W = 9;
    localparam int UPD_W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, upd_valid, upd_ready, pred_req, pred_grant, pred_stall;
    logic             squash, arr_ren, arr_wen, q_empty;
    logic [IDX_W-1:0] upd_idx, pred_idx, arr_ridx, arr_widx;
    logic [UPD_W-1:0] upd_data, arr_wdata;

    bpu_update_scheduler #(
        .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .IDX_W(IDX_W), .UPD_W(UPD_W)
    ) dut (
        .clk(clk), .rst(rst),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_data(upd_data),
        .pred_req(pred_req), .pred_idx(pred_idx), .pred_grant(pred_grant), .pred_stall(pred_stall),
        .squash(squash), .arr_ren(arr_ren), .arr_ridx(arr_ridx),
        .arr_wen(arr_wen), .arr_widx(arr_widx), .arr_wdata(arr_wdata), .q_empty(q_empty)
    );

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [UPD_W-1:0] data;
    } upd_t;

    upd_t sbq[$];
    bit   m_force = 1'b0;
    int   m_starve = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic             c_wen, c_grant, c_stall, c_ready, c_empty;
    logic [IDX_W-1:0] c_widx;

    function automatic void chk1(string nm, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chkv(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compare outputs against the model, pop the scoreboard on each
    // write, then advance the model with the inputs about to be sampled.
    int   m_sz;
    logic exp_wen, exp_grant;
    upd_t m_head;
    always @(negedge clk) begin
        m_sz      = sbq.size();
        exp_wen   = !rst && (m_sz > 0) && (m_force || !pred_req || squash);
        exp_grant = pred_req && !exp_wen && !squash;
        chk1("arr_wen", arr_wen, exp_wen);
        chk1("pred_grant", pred_grant, exp_grant);
        chk1("arr_ren", arr_ren, exp_grant);
        chk1("pred_stall", pred_stall, m_force);
        chk1("upd_ready", upd_ready, m_sz < DEPTH);
        chk1("q_empty", q_empty, m_sz == 0);
        chkv("arr_ridx", 64'(arr_ridx), 64'(pred_idx));
        if (exp_wen) begin
            m_head = sbq.pop_front();
            if (arr_wen) begin
                chkv("arr_widx", 64'(arr_widx), 64'(m_head.idx));
                chkv("arr_wdata", arr_wdata, m_head.data);
            end
        end
        if (rst) begin
            sbq.delete();
            m_force  = 1'b0;
            m_starve = 0;
        end else begin
            if (exp_wen)
                m_starve = 0;
            else if (m_sz > 0 && !m_force)
                m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            if (upd_valid && m_sz < DEPTH)
                sbq.push_back('{idx: upd_idx, data: upd_data});
            if (sbq.size() == 0)
                m_force = 1'b0;
            else if (m_force) begin
                if (sbq.size() <= DEPTH / 2) m_force = 1'b0;
            end else if (m_starve == LIMIT || sbq.size() == DEPTH)
                m_force = 1'b1;
        end
    end

    task automatic step(input logic v, input logic [IDX_W-1:0] ix, input logic [UPD_W-1:0] d,
                        input logic pr, input logic sq, input logic r);
        upd_valid = v;
        upd_idx   = ix;
        upd_data  = d;
        pred_req  = pr;
        pred_idx  = IDX_W'($urandom);
        squash    = sq;
        rst       = r;
        @(negedge clk);
        c_wen   = arr_wen;
        c_widx  = arr_widx;
        c_grant = pred_grant;
        c_stall = pred_stall;
        c_ready = upd_ready;
        c_empty = q_empty;
        @(posedge clk);
        #1;
    endtask

    logic [IDX_W-1:0] fidx [4];
    int grants;

    initial begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("rst_ready", c_ready, 1'b1);
        chk1("rst_empty", c_empty, 1'b1);
        chk1("rst_grant", c_grant, 1'b1);
        chk1("rst_stall", c_stall, 1'b0);

        // idle reads
        grants = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            grants += int'(c_grant);
        end
        chkv("idle_grants", 64'(grants), 64'd5);

        // gap write
        step(1'b1, 9'h012, 64'hDEAD_BEEF_0000_0012, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk1("gap_wen", c_wen, 1'b1);
        chkv("gap_widx", 64'(c_widx), 64'h012);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk1("gap_empty", c_empty, 1'b1);

        // starvation
        step(1'b1, 9'h0A7, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            chk1("starve_defer", c_wen, 1'b0);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("starve_force_wen", c_wen, 1'b1);
        chk1("starve_force_stall", c_stall, 1'b1);
        chk1("starve_force_grant", c_grant, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("starve_idle_stall", c_stall, 1'b0);
        chk1("starve_idle_wen", c_wen, 1'b0);

        // full queue
        for (int i = 0; i < 4; i++) begin
            fidx[i] = IDX_W'(9'h100 + i * 3);
            step(1'b1, fidx[i], {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
            chk1("fill_ready", c_ready, 1'b1);
        end
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("full_ready", c_ready, 1'b0);
        chk1("full_force_wen0", c_wen, 1'b1);
        chk1("full_force_stall", c_stall, 1'b1);
        chkv("full_order0", 64'(c_widx), 64'(fidx[0]));
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("full_force_wen1", c_wen, 1'b1);
        chkv("full_order1", 64'(c_widx), 64'(fidx[1]));
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("full_share_stall", c_stall, 1'b0);
        chk1("full_share_wen", c_wen, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chkv("full_order2", 64'(c_widx), 64'(fidx[2]));
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chkv("full_order3", 64'(c_widx), 64'(fidx[3]));

        // squash slot
        step(1'b1, 9'h155, 64'hCAFE_F00D_5555_AAAA, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk1("squash_wen", c_wen, 1'b1);
        chk1("squash_grant", c_grant, 1'b0);
        chkv("squash_widx", 64'(c_widx), 64'h155);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("squash_empty", c_empty, 1'b1);

        // reset while forcing with three entries, enqueue attempted in reset cycle
        for (int i = 0; i < 3; i++)
            step(1'b1, IDX_W'(9'h040 + i), {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9'h1FF, 64'h1, 1'b1, 1'b0, 1'b1);
        chk1("prerst_stall", c_stall, 1'b1);
        chk1("rstcyc_wen", c_wen, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk1("postrst_wen", c_wen, 1'b0);
        chk1("postrst_stall", c_stall, 1'b0);
        chk1("postrst_ready", c_ready, 1'b1);
        chk1("postrst_empty", c_empty, 1'b1);
        chk1("postrst_grant", c_grant, 1'b1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 6, IDX_W'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bpu_update_scheduler.md
BPU_UPDATE_SCHEDULER -- requirements
Module: bpu_update_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of update-queue entries (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, 8, the maximum number of consecutive cycles a queued update may be deferred by prediction reads.
REQ-003 SHALL have parameter IDX_W, 9, array set-index width.
REQ-004 SHALL have parameter UPD_W, 64, opaque update-payload width.
REQ-005 SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have ports upd_valid (input, 1), upd_ready (output, 1), upd_idx (input, IDX_W) and upd_data (input, UPD_W), forming the update request from the FSQ.
REQ-008 SHALL have ports pred_req (input, 1) and pred_idx (input, IDX_W), the prediction read request for the current cycle.
REQ-009 SHALL have port pred_grant, output, 1, which grants the read the array port this cycle.
REQ-010 SHALL have port pred_stall, output, 1, which requests a BPU pipeline stall, driving redirect.stall.
REQ-011 SHALL have port squash, input, 1, a BPU flush; no read is needed in that cycle.
REQ-012 SHALL have ports arr_ren (output, 1) and arr_ridx (output, IDX_W), the array read port.
REQ-013 SHALL have ports arr_wen (output, 1), arr_widx (output, IDX_W) and arr_wdata (output, UPD_W), the array write port.
REQ-014 SHALL have port q_empty, output, 1, asserted when the queue is empty and no write is pending.

Function
REQ-015 Single-ported array: per cycle exactly one of {arr_ren, arr_wen} or neither SHALL be asserted, never both.
REQ-016 Enqueue SHALL occur when upd_valid && upd_ready; upd_ready = !full, computed from registered count only, with no same-cycle dequeue bypass.
REQ-017 Latency: an update accepted in cycle t SHALL be written at the earliest in cycle t+1; queue order SHALL be FIFO.
REQ-018 arr_widx/arr_wdata SHALL be the queue head; arr_ridx = pred_idx; pred_grant = arr_ren = pred_req && !arr_wen && !squash.
REQ-019 FSM states: IDLE (count==0), SHARE (count>0, read priority) and FORCE (write priority).
REQ-020 IDLE: arr_wen=0, pred_stall=0; SHALL go to SHARE on an enqueue.
REQ-021 SHARE: arr_wen = !pred_req || squash; starve counter increments (saturating) each cycle the head is deferred and clears on every write.
REQ-022 SHARE->FORCE SHALL occur when starve==STARVE_LIMIT or count==DEPTH at the cycle edge.
REQ-023 SHARE->IDLE SHALL occur when the last entry is written with no simultaneous enqueue.
REQ-024 FORCE: pred_stall=1, arr_wen=1 every cycle, pred_grant=0.
REQ-025 FORCE SHALL exit to SHARE (starve cleared) once post-write count <= DEPTH/2 and >0, or to IDLE once count reaches 0.
REQ-026 A simultaneous enqueue and dequeue SHALL keep count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-027 squash SHALL NOT discard queued updates, because they are committed state; a squash cycle is a free write slot.
REQ-028 pred_stall SHALL be a registered output, decoded from state only.

Reset
REQ-029 On rst: count=0, pointers=0, state=IDLE, starve=0.
REQ-030 After rst, outputs SHALL be upd_ready=1, arr_wen=0, pred_stall=0, q_empty=1, pred_grant=arr_ren=pred_req.
REQ-031 rst mid-FORCE or mid-enqueue SHALL drop all queued entries with no write in the reset cycle.

Structure
REQ-032 The state enum (IDLE/SHARE/FORCE) and the default STARVE_LIMIT SHALL live in the shared frontend package; payload width SHALL be derived from BranchUpdateInfo there.
REQ-033 Queue storage SHALL be one sub-module, upd_fifo (parameters DEPTH, IDX_W+UPD_W; outputs full/empty/count); the FSM and arbitration SHALL stay in the top module.

Verification (DEPTH=4, STARVE_LIMIT=3)
REQ-034 Idle reads: pred_req=1 every cycle with no updates -> pred_grant=1, arr_wen=0, state IDLE throughout.
REQ-035 Gap write: enqueue idx 0x12 at t, pred_req=0 at t+1 -> arr_wen=1, arr_widx=0x12 at t+1; q_empty=1 at t+2.
REQ-036 Starvation: enqueue 1 update, pred_req=1 continuously -> head deferred 3 cycles, then FORCE; pred_stall=1 and write occurs at the 4th post-enqueue cycle; IDLE and pred_stall=0 the cycle after.
REQ-037 Full: enqueue 4 updates back-to-back under pred_req=1 -> upd_ready=0 at count 4, FORCE writes 2 entries, returns to SHARE at count 2, FIFO order preserved.
REQ-038 Squash slot: queue count 1, pred_req=1 and squash=1 -> arr_wen=1, pred_grant=0, no entry lost.
REQ-039 Reset in FORCE with count 3 -> next cycle count 0, arr_wen=0, pred_stall=0, upd_ready=1.
